// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_gen_if
//  Purpose  : Configuration request channel for led_pattern_gen.
//             valid/ready handshake carrying one channel configuration
//             (channel index, mode, period), plus an error pulse back to the
//             requester for requests that target a non-existent channel.
//  Signals  : cfg_valid  - requester has a config request
//             cfg_ready  - block can accept a request
//             cfg_ch     - target channel index
//             cfg_mode   - 0 OFF, 1 ON, 2 BLINK, 3 BREATHE
//             cfg_period - ticks per blink half-period / breathe step
//             cfg_err    - one-cycle pulse, request dropped (bad channel)
//  Revision : 1.0 - initial release
// ============================================================================
interface led_pattern_gen_if #(
    parameter int NUM_CH = 3
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [1:0]      cfg_mode;
    logic [7:0]      cfg_period;
    logic            cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period,
        output cfg_ready, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_gen
//  Purpose  : Multi-channel LED pattern generator. Each channel runs OFF, ON,
//             BLINK or BREATHE (triangle-ramped PWM duty) from a shared
//             timebase tick. Configuration arrives over a valid/ready channel
//             into a single pending slot and is applied on the next tick.
//  Ports    : clk     - system clock, rising edge
//             resetn  - synchronous, active-low reset
//             cfg     - configuration channel (slave side)
//             led     - registered LED pins, polarity set by ACTIVE_LOW
//  Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int NUM_CH     = 3,
    parameter int TICK_DIV   = 2_000_000,
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    led_pattern_gen_if.slave       cfg,
    output logic [NUM_CH-1:0]      led
);
    localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_PRE_W = $clog2(TICK_DIV);

    localparam logic [1:0] c_MODE_OFF     = 2'd0;
    localparam logic [1:0] c_MODE_ON      = 2'd1;
    localparam logic [1:0] c_MODE_BLINK   = 2'd2;
    localparam logic [1:0] c_MODE_BREATHE = 2'd3;

    localparam logic                c_POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [PWM_BITS-1:0] c_DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0] c_DUTY_ONE = PWM_BITS'(1);

    // ------------------------------------------------------------------
    // Timebase prescaler and free-running PWM counter
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0]  r_pre;
    logic [PWM_BITS-1:0] r_pwm;
    logic                w_tick;

    assign w_tick = (r_pre == c_PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pre <= '0;
            r_pwm <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + c_PRE_W'(1);
            r_pwm <= r_pwm + PWM_BITS'(1);
        end
    end

    // ------------------------------------------------------------------
    // Config handshake and single pending slot
    // ------------------------------------------------------------------
    logic              r_pend;
    logic [c_CH_W-1:0] r_pend_ch;
    logic [1:0]        r_pend_mode;
    logic [7:0]        r_pend_period;
    logic              r_err;
    logic              w_xfer;
    logic              w_bad_ch;
    logic              w_apply;
    logic [31:0]       w_ch_ext;

    assign cfg.cfg_ready = resetn & ~r_pend;
    assign cfg.cfg_err   = r_err;
    assign w_xfer        = cfg.cfg_valid & cfg.cfg_ready;
    assign w_ch_ext      = 32'(cfg.cfg_ch);
    assign w_bad_ch      = (w_ch_ext >= 32'(NUM_CH));
    // r_pend only becomes visible the cycle after capture, so a request
    // captured during a tick cycle naturally waits for the following tick.
    assign w_apply       = r_pend & w_tick;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pend        <= 1'b0;
            r_pend_ch     <= '0;
            r_pend_mode   <= c_MODE_OFF;
            r_pend_period <= 8'd1;
            r_err         <= 1'b0;
        end else begin
            r_err <= w_xfer & w_bad_ch;
            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (w_xfer && !w_bad_ch) begin
                r_pend        <= 1'b1;
                r_pend_ch     <= cfg.cfg_ch;
                r_pend_mode   <= cfg.cfg_mode;
                r_pend_period <= cfg.cfg_period;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel pattern engines
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]          r_mode;
        logic [7:0]          r_period;
        logic [7:0]          r_phase;
        logic                r_blink;
        logic [PWM_BITS-1:0] r_duty;
        logic                r_down;
        logic                r_led;
        logic [7:0]          w_per_m1;
        logic                w_anim;
        logic                w_step;
        logic                w_apply_ch;
        logic                w_lit;

        // A period of 0 behaves as 1.
        assign w_per_m1   = (r_period == 8'd0) ? 8'd0 : r_period - 8'd1;
        assign w_anim     = (r_mode == c_MODE_BLINK) || (r_mode == c_MODE_BREATHE);
        assign w_step     = w_tick && w_anim && (r_phase == w_per_m1);
        assign w_apply_ch = w_apply && (r_pend_ch == c_CH_W'(g));

        always_comb begin
            w_lit = 1'b0;
            case (r_mode)
                c_MODE_ON:      w_lit = 1'b1;
                c_MODE_BLINK:   w_lit = r_blink;
                c_MODE_BREATHE: w_lit = (r_pwm < r_duty);
                default:        w_lit = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_mode   <= c_MODE_OFF;
                r_period <= 8'd1;
                r_phase  <= 8'd0;
                r_blink  <= 1'b0;
                r_duty   <= '0;
                r_down   <= 1'b0;
                r_led    <= c_POL;
            end else begin
                r_led <= w_lit ^ c_POL;
                // Apply wins over a coincident step on this channel.
                if (w_apply_ch) begin
                    r_mode   <= r_pend_mode;
                    r_period <= r_pend_period;
                    r_phase  <= 8'd0;
                    r_blink  <= 1'b0;
                    r_duty   <= '0;
                    r_down   <= 1'b0;
                end else if (w_tick && w_anim) begin
                    r_phase <= w_step ? 8'd0 : r_phase + 8'd1;
                    if (w_step) begin
                        if (r_mode == c_MODE_BLINK) begin
                            r_blink <= ~r_blink;
                        end else begin
                            // Triangle ramp: turn around at the extremes so
                            // the duty never wraps.
                            if (!r_down) begin
                                if (r_duty != c_DUTY_MAX) r_duty <= r_duty + c_DUTY_ONE;
                                if (r_duty == c_DUTY_MAX - c_DUTY_ONE) r_down <= 1'b1;
                            end else begin
                                if (r_duty != '0) r_duty <= r_duty - c_DUTY_ONE;
                                if (r_duty == c_DUTY_ONE) r_down <= 1'b0;
                            end
                        end
                    end
                end
            end
        end

        assign led[g] = r_led;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_gen
//  Purpose  : Self-checking bench for led_pattern_gen. The reference model
//             tracks, per channel, the mode, period and the tick at which the
//             config was applied, and derives the expected pattern from the
//             number of ticks elapsed since then.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;
    localparam int NUM_CH     = 3;
    localparam int TICK_DIV   = 4;
    localparam int PWM_BITS   = 3;
    localparam int ACTIVE_LOW = 1;
    localparam int DMAX       = (1 << PWM_BITS) - 1;

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic [NUM_CH-1:0] led;

    led_pattern_gen_if #(.NUM_CH(NUM_CH)) cfg ();

    led_pattern_gen #(
        .NUM_CH     (NUM_CH),
        .TICK_DIV   (TICK_DIV),
        .PWM_BITS   (PWM_BITS),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .cfg    (cfg.slave),
        .led    (led)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_cyc   = 0;   // cycles since reset release
    int m_ticks = 0;   // ticks completed before the current cycle
    bit m_pend  = 1'b0;
    int m_pch, m_pmode, m_pper;
    bit m_err   = 1'b0;
    int m_mode [NUM_CH];
    int m_per  [NUM_CH];
    int m_a    [NUM_CH];  // index of the tick on which the config was applied

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit model_lit(input int c);
        int p, steps, m, duty;
        p     = (m_per[c] == 0) ? 1 : m_per[c];
        steps = (m_ticks - m_a[c] - 1) / p;
        case (m_mode[c])
            1: return 1'b1;
            2: return (steps % 2) == 1;
            3: begin
                m    = steps % (2 * DMAX);
                duty = (m <= DMAX) ? m : 2 * DMAX - m;
                return (m_cyc % (DMAX + 1)) < duty;
            end
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: check ready against the current inputs, advance the
    // model across the edge, then check the registered outputs.
    task automatic cycle(output bit accepted);
        bit rst_now, tick_now, ready_now, xfer, bad;
        logic [NUM_CH-1:0] exp_led;
        int ch;
        #1;
        rst_now   = !resetn;
        ready_now = !rst_now && !m_pend;
        check("cfg_ready", 8'(cfg.cfg_ready), 8'(ready_now));
        tick_now  = !rst_now && ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        xfer      = cfg.cfg_valid && ready_now;
        ch        = int'(cfg.cfg_ch);
        bad       = (ch >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++)
            exp_led[c] = rst_now ? 1'b1 : (model_lit(c) ^ 1'b1);
        accepted = xfer;

        @(posedge clk);
        if (rst_now) begin
            m_cyc   = 0;
            m_ticks = 0;
            m_pend  = 1'b0;
            m_err   = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0;
                m_per[c]  = 1;
                m_a[c]    = 0;
            end
        end else begin
            m_err = xfer && bad;
            if (tick_now) begin
                if (m_pend) begin
                    m_mode[m_pch] = m_pmode;
                    m_per[m_pch]  = m_pper;
                    m_a[m_pch]    = m_ticks;
                    m_pend        = 1'b0;
                end
                m_ticks++;
            end
            if (xfer && !bad) begin
                m_pend  = 1'b1;
                m_pch   = ch;
                m_pmode = int'(cfg.cfg_mode);
                m_pper  = int'(cfg.cfg_period);
            end
            m_cyc++;
        end
        #1;
        check("led", 8'(led), 8'(exp_led));
        check("cfg_err", 8'(cfg.cfg_err), 8'(m_err));
    endtask

    task automatic run(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic send(input int ch, input int mode, input int per);
        bit acc;
        int n;
        n = 0;
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_ch     = 2'(ch);
        cfg.cfg_mode   = 2'(mode);
        cfg.cfg_period = 8'(per);
        do begin
            cycle(acc);
            n++;
        end while (!acc && n < 50);
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        cfg.cfg_valid  = 1'b0;
        cfg.cfg_ch     = '0;
        cfg.cfg_mode   = '0;
        cfg.cfg_period = '0;

        // Reset state
        resetn = 1'b0;
        run(3);
        resetn = 1'b1;

        // Idle: all LEDs dark, ready high, no error
        run(20);

        // ch1 ON
        send(1, 1, 1);
        run(12);

        // ch0 BLINK period 2
        send(0, 2, 2);
        run(40);

        // ch2 BREATHE period 1: full ramp up and down, and beyond
        send(2, 3, 1);
        run(130);

        // Out-of-range channel: accepted, error pulse, nothing changes
        send(3, 1, 1);
        run(10);

        // valid held high: next request waits until the pending one applies
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_ch     = 2'd1;
        cfg.cfg_mode   = 2'd2;
        cfg.cfg_period = 8'd1;
        run(15);
        cfg.cfg_valid = 1'b0;
        run(5);

        // Randomized traffic, including period 0 and bad channels
        for (int i = 0; i < 300; i++) begin
            cfg.cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg.cfg_ch     = 2'($urandom_range(0, 3));
            cfg.cfg_mode   = 2'($urandom_range(0, 3));
            cfg.cfg_period = 8'($urandom_range(0, 3));
            cycle(acc);
        end
        cfg.cfg_valid = 1'b0;

        // One-cycle reset while ch0 blinks with a request pending
        send(0, 2, 2);
        run(30);
        send(1, 3, 1);
        resetn = 1'b0;
        cycle(acc);
        resetn = 1'b1;
        run(30);

        // More random traffic after reset
        for (int i = 0; i < 200; i++) begin
            cfg.cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg.cfg_ch     = 2'($urandom_range(0, 3));
            cfg.cfg_mode   = 2'($urandom_range(0, 3));
            cfg.cfg_period = 8'($urandom_range(0, 2));
            cycle(acc);
        end
        cfg.cfg_valid = 1'b0;
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_CH, default 3: number of LED channels, 1..8.
REQ-002 Parameter TICK_DIV, default 2_000_000: clk cycles per timebase tick, >=2.
REQ-003 Parameter PWM_BITS, default 8: breathe duty and PWM counter width.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = led pins driven low when lit.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 cfg_valid  input  1  config request present.
REQ-008 cfg_ready  output  1  block can accept a config request.
REQ-009 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel index.
REQ-010 cfg_mode  input  2  0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
REQ-011 cfg_period  input  8  ticks per blink half-period / per breathe duty step; 0 treated as 1.
REQ-012 cfg_err  output  1  one-cycle pulse: dropped request with cfg_ch >= NUM_CH.
REQ-013 led  output  NUM_CH  registered LED pins, polarity per ACTIVE_LOW.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1, wraps to 0; internal tick is high exactly in the cycle count == TICK_DIV-1.
REQ-015 Handshake: transfer when cfg_valid && cfg_ready; cfg_ch, cfg_mode, cfg_period are captured into a single pending slot on that edge.
REQ-016 cfg_ready = 0 while resetn low, else = not pending; at most one request is outstanding.
REQ-017 Pending request is applied in the first tick cycle strictly after the capture cycle; a request captured in a tick cycle waits for the next tick; pending clears on apply.
REQ-018 Request with cfg_ch >= NUM_CH: accepted, never applied, pending not set, cfg_err = 1 the cycle after acceptance, channel state unchanged.
REQ-019 Apply to channel c: mode/period loaded; phase counter = 0; blink state = unlit; duty = 0; direction = up.
REQ-020 Per-channel step event: on a tick where phase == period-1 (period 0 as 1), phase wraps to 0; otherwise phase increments on each tick; phase is held in OFF/ON.
REQ-021 Apply takes precedence over a coincident step event on the same channel; other channels step normally.
REQ-022 OFF: lit = 0. ON: lit = 1.
REQ-023 BLINK: blink state toggles on each step event; lit = blink state.
REQ-024 BREATHE: on each step event duty += 1 when up, -= 1 when down; duty reaching 2^PWM_BITS-1 sets down, reaching 0 sets up; no overflow or underflow.
REQ-025 PWM counter is PWM_BITS wide, free-running every clk, wraps; BREATHE lit = (pwm_cnt < duty).
REQ-026 led[c] is registered from lit, one clk latency: led[c] = lit XOR ACTIVE_LOW.
REQ-027 Channels are fully independent; a config to one channel never disturbs another channel's phase, duty or state.

Reset
REQ-028 While resetn low: prescaler, PWM counter, phase, duty = 0; all modes = OFF; period = 1; direction = up; pending = 0; cfg_err = 0.
REQ-029 led = all ones when ACTIVE_LOW = 1, all zeros otherwise, from the first clk edge with resetn low.
REQ-030 Reset mid-operation discards any pending request and returns all state to REQ-028 values at the same edge.
REQ-031 First tick after release occurs TICK_DIV cycles after the first cycle with resetn high.

Verification (TICK_DIV=4, PWM_BITS=3, NUM_CH=3, ACTIVE_LOW=1)
REQ-032 Reset release, no config -> led = 3'b111 indefinitely; cfg_ready = 1; cfg_err never pulses.
REQ-033 ch1 ON -> led[1] = 0 by 2 cycles after the next tick; cfg_ready low from capture until apply, then high.
REQ-034 ch0 BLINK, period 2 -> led[0] toggles every 8 clk, first falling edge 8 clk after apply.
REQ-035 ch2 BREATHE, period 1 -> duty ramps 0..7..0 one step per tick; per 8-clk PWM window, lit count equals duty.
REQ-036 cfg_ch = 3 -> accepted, cfg_err pulses once, all led unchanged; cfg_valid held while pending -> second request not accepted until apply.
REQ-037 resetn pulsed low for 1 cycle while ch0 is blinking with a request pending -> led = 3'b111 next edge; pending request never applied.
